alu_result_stage: RTL and testbench

- Downstream consumer of the ALU's zHI/zLOW outputs; sits between the ALU and register writeback.
- Issues ALU ops under a valid/ready handshake and waits out the pipelined multiplier latency.
- Captures 64-bit results into a small FIFO, tagged with opcode and flags.
- Drains results to writeback under a second handshake and updates the architectural HI/LO registers on mul/div retirement.

---
 rtl/alu_result_stage_if.sv | 31 +++
 rtl/alu_result_stage.sv | 131 +++++++++++++
 tb/tb_alu_result_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - issue, ALU result and writeback signals of the ALU result stage
interface alu_result_stage_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  ctrl;
  logic [31:0] zHI;
  logic [31:0] zLOW;
  logic        alu_hold;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic [4:0]  res_op;
  logic        res_zero;
  logic        res_neg;
  logic        res_err;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport slave (
    input  issue_valid, ctrl, zHI, zLOW, res_ready,
    output issue_ready, alu_hold, res_valid, res_lo, res_hi, res_op,
           res_zero, res_neg, res_err, hi_q, lo_q
  );

  modport master (
    output issue_valid, ctrl, zHI, zLOW, res_ready,
    input  issue_ready, alu_hold, res_valid, res_lo, res_hi, res_op,
           res_zero, res_neg, res_err, hi_q, lo_q
  );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - issues ALU ops, waits out multiplier latency, queues tagged results, retires HI/LO
module alu_result_stage #(
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 2
) (
  input logic               clk,
  input logic               clr,
  alu_result_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MAX = 5'b01011;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            push, pop, accept;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;

  logic [31:0]     mem_lo  [DEPTH];
  logic [31:0]     mem_hi  [DEPTH];
  logic [4:0]      mem_op  [DEPTH];
  logic [2:0]      mem_flg [DEPTH];

  logic [4:0]      cap_op;
  logic            cap_mul, cap_div, cap_err, cap_zero, cap_neg;
  logic [31:0]     cap_lo, cap_hi;

  assign bus.issue_ready = (state == IDLE) && (count < (PW+1)'(DEPTH));
  assign bus.alu_hold    = (state == WAIT);
  assign bus.res_valid   = (count != '0);
  assign accept          = bus.issue_valid && bus.issue_ready;
  assign pop             = bus.res_valid && bus.res_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.ctrl == OP_MUL && MUL_LAT != 0) begin
            state_nx = WAIT;
            cnt_nx   = CW'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);
          end else begin
            push = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          push     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only a mul can be pending in WAIT, so the captured opcode is implied by the state.
  always_comb begin
    cap_op   = (state == WAIT) ? OP_MUL : bus.ctrl;
    cap_mul  = (cap_op == OP_MUL);
    cap_div  = (cap_op == OP_DIV);
    cap_err  = (cap_op > OP_MAX);
    cap_lo   = cap_err ? 32'd0 : bus.zLOW;
    cap_hi   = (cap_mul || cap_div) ? bus.zHI : 32'd0;
    cap_zero = !cap_err && (cap_mul ? (bus.zLOW == 32'd0 && bus.zHI == 32'd0)
                                    : (bus.zLOW == 32'd0));
    cap_neg  = !cap_err && (cap_mul ? bus.zHI[31] : bus.zLOW[31]);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.hi_q <= 32'd0;
      bus.lo_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_lo[i]  <= 32'd0;
        mem_hi[i]  <= 32'd0;
        mem_op[i]  <= 5'd0;
        mem_flg[i] <= 3'd0;
      end
    end else begin
      if (push) begin
        mem_lo[wr_ptr]  <= cap_lo;
        mem_hi[wr_ptr]  <= cap_hi;
        mem_op[wr_ptr]  <= cap_op;
        mem_flg[wr_ptr] <= {cap_err, cap_neg, cap_zero};
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (bus.res_op == OP_MUL || bus.res_op == OP_DIV) begin
          bus.hi_q <= bus.res_hi;
          bus.lo_q <= bus.res_lo;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.res_lo   = mem_lo[rd_ptr];
  assign bus.res_hi   = mem_hi[rd_ptr];
  assign bus.res_op   = mem_op[rd_ptr];
  assign bus.res_err  = mem_flg[rd_ptr][2];
  assign bus.res_neg  = mem_flg[rd_ptr][1];
  assign bus.res_zero = mem_flg[rd_ptr][0];
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed bench for alu_result_stage with a queue-based reference model
module tb_alu_result_stage;
  localparam int DEPTH   = 2;
  localparam int MUL_LAT = 2;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_BAD = 5'b11111;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  op;
    logic        zero;
    logic        neg;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] alu_lo, alu_hi;
  logic [63:0] pipe [MUL_LAT];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_result_stage_if bus();
  alu_result_stage #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .clr(clr), .bus(bus));

  // Stand-in ALU: pipelined multiplier, junk on zHI for ops that should not use it.
  always @(posedge clk) begin
    pipe[0] <= 64'(a) * 64'(b);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    alu_hi = 32'hBAD0_BAD0;
    alu_lo = a ^ b;
    case (bus.ctrl)
      OP_ADD: alu_lo = a + b;
      OP_SUB: alu_lo = a - b;
      OP_MUL: {alu_hi, alu_lo} = pipe[MUL_LAT-1];
      OP_DIV: begin
        alu_lo = (b != 0) ? a / b : 32'd0;
        alu_hi = (b != 0) ? a % b : 32'd0;
      end
      default: ;
    endcase
  end

  assign bus.zHI  = alu_hi;
  assign bus.zLOW = alu_lo;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ent_t model_entry(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    ent_t e;
    logic [63:0] p;
    e = '0;
    e.op = op;
    if (op > 5'd11) begin
      e.err = 1'b1;
      return e;
    end
    case (op)
      OP_ADD: e.lo = x + y;
      OP_SUB: e.lo = x - y;
      OP_MUL: begin
        p = 64'(x) * 64'(y);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_DIV: begin
        e.lo = (y != 0) ? x / y : 32'd0;
        e.hi = (y != 0) ? x % y : 32'd0;
      end
      default: e.lo = x ^ y;
    endcase
    e.zero = (op == OP_MUL) ? ({e.hi, e.lo} == 64'd0) : (e.lo == 32'd0);
    e.neg  = (op == OP_MUL) ? e.hi[31] : e.lo[31];
    return e;
  endfunction

  // Reference model: compares at each negedge, then advances to the state after the next posedge.
  ent_t        q[$];
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic        m_wait = 0;
  int          m_left = 0;

  always @(negedge clk) begin
    logic exp_ready, do_pop;
    if (!clr) begin
      q.delete();
      m_hi = 0; m_lo = 0; m_wait = 0; m_left = 0;
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_alu_hold", bus.alu_hold, 0);
      chk("rst_hi_q", bus.hi_q, 0);
      chk("rst_lo_q", bus.lo_q, 0);
      chk("rst_res_data", {bus.res_hi, bus.res_lo}, 0);
    end else begin
      exp_ready = !m_wait && (q.size() < DEPTH);
      chk("issue_ready", bus.issue_ready, exp_ready);
      chk("alu_hold", bus.alu_hold, m_wait);
      chk("res_valid", bus.res_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("res_lo", bus.res_lo, q[0].lo);
        chk("res_hi", bus.res_hi, q[0].hi);
        chk("res_op", bus.res_op, q[0].op);
        chk("res_flags", {bus.res_zero, bus.res_neg, bus.res_err}, {q[0].zero, q[0].neg, q[0].err});
      end
      chk("hi_q", bus.hi_q, m_hi);
      chk("lo_q", bus.lo_q, m_lo);
      do_pop = (q.size() > 0) && bus.res_ready;
      if (do_pop) begin
        if (q[0].op == OP_MUL || q[0].op == OP_DIV) begin
          m_hi = q[0].hi;
          m_lo = q[0].lo;
        end
        void'(q.pop_front());
      end
      if (m_wait) begin
        if (m_left == 0) begin
          q.push_back(model_entry(OP_MUL, m_a, m_b));
          m_wait = 0;
        end else begin
          m_left--;
        end
      end else if (bus.issue_valid && exp_ready) begin
        if (bus.ctrl == OP_MUL) begin
          m_wait = 1; m_left = MUL_LAT - 1; m_a = a; m_b = b;
        end else begin
          q.push_back(model_entry(bus.ctrl, a, b));
        end
      end
    end
  end

  task automatic do_issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, output int holds);
    int t;
    holds = 0;
    t = 0;
    bus.ctrl = op; a = x; b = y; bus.issue_valid = 1'b1;
    @(negedge clk);
    while (!bus.issue_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("issue_timeout", 1, 0);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    if (op == OP_MUL) begin
      t = 0;
      while (bus.alu_hold && t < 50) begin
        holds++;
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) chk("hold_timeout", 1, 0);
    end
  endtask

  initial begin
    ent_t e;
    int   h;
    bus.issue_valid = 1'b0;
    bus.ctrl = OP_ADD;
    bus.res_ready = 1'b1;
    #1 clr = 1'b0;

    e = model_entry(OP_ADD, 5, 7);                 chk("pin_add_lo", e.lo, 12);
    e = model_entry(OP_SUB, 3, 5);                 chk("pin_sub", {e.lo, e.hi, e.neg}, {32'hFFFF_FFFE, 32'd0, 1'b1});
    e = model_entry(OP_MUL, 32'h10000, 32'h10000); chk("pin_mul", {e.hi, e.lo, e.zero}, {32'd1, 32'd0, 1'b0});
    e = model_entry(OP_DIV, 17, 5);                chk("pin_div", {e.hi, e.lo}, {32'd2, 32'd3});
    e = model_entry(OP_BAD, 1, 2);                 chk("pin_bad", {e.err, e.lo}, {1'b1, 32'd0});

    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    bus.ctrl = OP_MUL; a = 32'd3; b = 32'd4; bus.issue_valid = 1'b1;
    @(posedge clk); #1 bus.issue_valid = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    chk("midwait_res_valid", bus.res_valid, 0);
    chk("midwait_hilo", {bus.hi_q, bus.lo_q}, 64'd0);
    chk("midwait_issue_ready", bus.issue_ready, 1);
    repeat (4) @(negedge clk);
    chk("midwait_no_stale", bus.res_valid, 0);

    @(posedge clk); #1;
    do_issue(OP_ADD, 5, 7, h);
    do_issue(OP_SUB, 3, 5, h);

    do_issue(OP_MUL, 32'h10000, 32'h10000, h);
    chk("mul_hold_cycles", h, 2);
    repeat (2) @(negedge clk);
    chk("mul_hi_q", bus.hi_q, 1);
    chk("mul_lo_q", bus.lo_q, 0);

    do_issue(OP_DIV, 17, 5, h);
    do_issue(OP_ADD, 100, 200, h);
    repeat (3) @(negedge clk);
    chk("div_lo_q", bus.lo_q, 3);
    chk("div_hi_q", bus.hi_q, 2);

    @(posedge clk); #1 bus.res_ready = 1'b0;
    do_issue(OP_ADD, 1, 1, h);
    do_issue(OP_ADD, 2, 2, h);
    @(negedge clk);
    chk("bp_ready_low", bus.issue_ready, 0);
    fork
      do_issue(OP_ADD, 3, 3, h);
      begin
        repeat (3) @(posedge clk);
        #1 bus.res_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    @(posedge clk); #1 bus.res_ready = 1'b0;
    do_issue(OP_BAD, 9, 9, h);
    bus.res_ready = 1'b1;
    do_issue(OP_ADD, 8, 8, h);
    @(negedge clk);
    chk("pushpop_valid", bus.res_valid, 1);
    chk("pushpop_head_op", bus.res_op, OP_ADD);
    chk("bad_keeps_lo_q", bus.lo_q, 3);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
